// File: rtl/avr_bus_if.sv
// Command/response handshake and SRAM-side bus of the AVR-to-CPLD access path.
// The master modport is the initiator (avr_bus_master). The slave modport is the host/bus side.
interface avr_bus_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  sreg_si;
    logic                  sreg_clk;
    logic                  sreg_en;
    logic                  bus_ce_n;
    logic                  bus_we_n;
    logic                  bus_oe_n;
    logic [DATA_WIDTH-1:0] bus_data_out;
    logic                  bus_data_oe;
    logic [DATA_WIDTH-1:0] bus_data_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
        output cmd_ready, rsp_valid, rsp_rdata, sreg_si, sreg_clk, sreg_en,
               bus_ce_n, bus_we_n, bus_oe_n, bus_data_out, bus_data_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
        input  cmd_ready, rsp_valid, rsp_rdata, sreg_si, sreg_clk, sreg_en,
               bus_ce_n, bus_we_n, bus_oe_n, bus_data_out, bus_data_oe
    );
endinterface

// File: rtl/avr_bus_master.sv
// Shifts a command address MSB-first into the CPLD address register.
// Then performs one strobed SRAM read or write and pulses rsp_valid when it completes.
module avr_bus_master #(
    parameter int ADDR_WIDTH    = 21,
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_DIV       = 2,
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    avr_bus_if.master  bus
);
    localparam int TMAX = (CLK_DIV > STROBE_CYCLES) ? CLK_DIV : STROBE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam logic [TW-1:0] T_DIV  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_STB  = TW'(STROBE_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(ADDR_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SHIFT_LO, ST_SHIFT_HI, ST_SETUP, ST_STROBE, ST_HOLD
    } state_t;

    state_t                r_state,     w_state_next;
    logic [TW-1:0]         r_timer,     w_timer_next;
    logic [BW-1:0]         r_bitcnt,    w_bitcnt_next;
    logic [ADDR_WIDTH-1:0] r_shift,     w_shift_next;
    logic                  r_write,     w_write_next;
    logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_next;
    logic [DATA_WIDTH-1:0] r_rdata,     w_rdata_next;
    logic                  r_rsp_valid, w_rsp_valid_next;
    logic                  r_si,        w_si_next;
    logic                  r_sclk,      w_sclk_next;
    logic                  r_en,        w_en_next;
    logic                  r_ce_n,      w_ce_n_next;
    logic                  r_we_n,      w_we_n_next;
    logic                  r_oe_n,      w_oe_n_next;
    logic                  r_doe,       w_doe_next;
    logic [DATA_WIDTH-1:0] r_dout,      w_dout_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_si        <= 1'b0;
            r_sclk      <= 1'b0;
            r_en        <= 1'b0;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_doe       <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_bitcnt    <= w_bitcnt_next;
            r_shift     <= w_shift_next;
            r_write     <= w_write_next;
            r_wdata     <= w_wdata_next;
            r_rdata     <= w_rdata_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_si        <= w_si_next;
            r_sclk      <= w_sclk_next;
            r_en        <= w_en_next;
            r_ce_n      <= w_ce_n_next;
            r_we_n      <= w_we_n_next;
            r_oe_n      <= w_oe_n_next;
            r_doe       <= w_doe_next;
            r_dout      <= w_dout_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_timer_next     = r_timer;
        w_bitcnt_next    = r_bitcnt;
        w_shift_next     = r_shift;
        w_write_next     = r_write;
        w_wdata_next     = r_wdata;
        w_rdata_next     = r_rdata;
        w_rsp_valid_next = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_write_next  = bus.cmd_write;
                    w_wdata_next  = bus.cmd_wdata;
                    w_shift_next  = bus.cmd_addr;
                    w_bitcnt_next = B_LAST;
                    w_timer_next  = T_DIV;
                    w_state_next  = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (r_timer == '0) begin
                    w_timer_next = T_DIV;
                    w_state_next = ST_SHIFT_HI;
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (r_timer != '0) begin
                    w_timer_next = r_timer - TW'(1);
                end else if (r_bitcnt == '0) begin
                    w_state_next = ST_SETUP;
                end else begin
                    w_shift_next  = {r_shift[ADDR_WIDTH-2:0], 1'b0};
                    w_bitcnt_next = r_bitcnt - BW'(1);
                    w_timer_next  = T_DIV;
                    w_state_next  = ST_SHIFT_LO;
                end
            end
            ST_SETUP: begin
                w_timer_next = T_STB;
                w_state_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (r_timer == '0) begin
                    // The read data is captured on the same edge that releases oe_n.
                    if (!r_write) begin
                        w_rdata_next = bus.bus_data_in;
                    end
                    w_state_next = ST_HOLD;
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            ST_HOLD: begin
                w_rsp_valid_next = 1'b1;
                w_state_next     = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Registered outputs are decoded from the state being entered, so they line up with it.
        w_si_next   = 1'b0;
        w_sclk_next = 1'b0;
        w_en_next   = 1'b0;
        w_ce_n_next = 1'b1;
        w_we_n_next = 1'b1;
        w_oe_n_next = 1'b1;
        w_doe_next  = 1'b0;
        w_dout_next = r_dout;
        unique case (w_state_next)
            ST_SHIFT_LO: begin
                w_en_next = 1'b1;
                w_si_next = w_shift_next[ADDR_WIDTH-1];
            end
            ST_SHIFT_HI: begin
                w_en_next   = 1'b1;
                w_sclk_next = 1'b1;
                w_si_next   = w_shift_next[ADDR_WIDTH-1];
            end
            ST_SETUP: begin
                w_ce_n_next = 1'b0;
                if (w_write_next) begin
                    w_doe_next  = 1'b1;
                    w_dout_next = w_wdata_next;
                end
            end
            ST_STROBE: begin
                w_ce_n_next = 1'b0;
                if (w_write_next) begin
                    w_we_n_next = 1'b0;
                    w_doe_next  = 1'b1;
                end else begin
                    w_oe_n_next = 1'b0;
                end
            end
            ST_HOLD: begin
                w_ce_n_next = 1'b0;
                w_doe_next  = w_write_next;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready    = (r_state == ST_IDLE);
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rdata;
    assign bus.sreg_si      = r_si;
    assign bus.sreg_clk     = r_sclk;
    assign bus.sreg_en      = r_en;
    assign bus.bus_ce_n     = r_ce_n;
    assign bus.bus_we_n     = r_we_n;
    assign bus.bus_oe_n     = r_oe_n;
    assign bus.bus_data_oe  = r_doe;
    assign bus.bus_data_out = r_dout;
endmodule

// File: tb/tb_avr_bus_master.sv
// Scoreboard bench for avr_bus_master: a default-parameter instance plus a CLK_DIV=1/STROBE_CYCLES=1 instance.
// Stimulus pushes expected responses. Negedge monitors pop them and compare on rsp_valid.
module tb_avr_bus_master;
    typedef struct {
        logic        w;
        logic [20:0] a;
        logic [7:0]  d;
        logic [7:0]  r;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] rd_val_f = 8'h00;
    logic [7:0] exp_rdata = 8'h00;
    logic [7:0] exp_rdata_f = 8'h00;

    exp_t exp_q[$];
    exp_t fq[$];

    avr_bus_if #(.ADDR_WIDTH(21), .DATA_WIDTH(8)) bm();
    avr_bus_if #(.ADDR_WIDTH(21), .DATA_WIDTH(8)) bf();

    avr_bus_master #(.ADDR_WIDTH(21), .DATA_WIDTH(8), .CLK_DIV(2), .STROBE_CYCLES(2))
        dut (.clk(clk), .reset_n(reset_n), .bus(bm));
    avr_bus_master #(.ADDR_WIDTH(21), .DATA_WIDTH(8), .CLK_DIV(1), .STROBE_CYCLES(1))
        dut_fast (.clk(clk), .reset_n(reset_n), .bus(bf));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: drives read data only while oe_n is asserted
    assign bm.bus_data_in = bm.bus_oe_n ? 8'h00 : rd_val;
    assign bf.bus_data_in = bf.bus_oe_n ? 8'h00 : rd_val_f;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Main monitor: shift-register model, strobe counters, protocol rules, response scoreboard
    int          edges = 0, we_cnt = 0, oe_cnt = 0, viol = 0, acc_cyc = 0;
    logic [20:0] cap = '0;
    logic [7:0]  dout_seen = '0;
    logic        prev_sclk = 1'b0, prev_si = 1'b0, prev_rv = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (!reset_n) begin
            edges = 0; we_cnt = 0; oe_cnt = 0; viol = 0; cap = '0;
            prev_sclk = 1'b0; prev_si = 1'b0; prev_rv = 1'b0;
        end else begin
            if (bm.sreg_clk && !prev_sclk) begin
                cap = {cap[19:0], bm.sreg_si};
                edges++;
            end
            if (bm.sreg_clk && prev_sclk && (bm.sreg_si != prev_si)) viol++;
            if (!bm.bus_we_n) begin
                we_cnt++;
                dout_seen = bm.bus_data_out;
                if (!bm.bus_data_oe) viol++;
            end
            if (!bm.bus_oe_n) begin
                oe_cnt++;
                if (bm.bus_data_oe) viol++;
            end
            if (!bm.bus_we_n && !bm.bus_oe_n) viol++;
            if (!bm.bus_ce_n && bm.sreg_en) viol++;
            if (bm.rsp_valid && prev_rv) viol++;
            if (bm.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, bm.rsp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - acc_cyc, 88);
                    chk("sclk_edges", edges, 21);
                    chk("shifted_addr", {11'd0, cap}, {11'd0, e.a});
                    chk("rsp_rdata", {24'd0, bm.rsp_rdata}, {24'd0, e.r});
                    chk("ce_n_at_rsp", {31'd0, bm.bus_ce_n}, 32'd1);
                    chk("data_oe_at_rsp", {31'd0, bm.bus_data_oe}, 32'd0);
                    if (e.w) begin
                        chk("we_low_cycles", we_cnt, 2);
                        chk("oe_low_cycles", oe_cnt, 0);
                        chk("bus_data_out", {24'd0, dout_seen}, {24'd0, e.d});
                    end else begin
                        chk("oe_low_cycles", oe_cnt, 2);
                        chk("we_low_cycles", we_cnt, 0);
                    end
                    chk("protocol_rules", viol, 0);
                    $display("rsp %s addr=%06h wdata=%02h rdata=%02h at cycle %0d",
                             e.w ? "WR" : "RD", cap, dout_seen, bm.rsp_rdata, cyc);
                end
            end
            if (bm.cmd_valid && bm.cmd_ready) begin
                acc_cyc = cyc + 1;
                edges = 0; we_cnt = 0; oe_cnt = 0; viol = 0; cap = '0;
            end
            prev_sclk = bm.sreg_clk;
            prev_si   = bm.sreg_si;
            prev_rv   = bm.rsp_valid;
        end
    end

    // Fast-instance monitor: one-cycle shift phases, latency 45, captured address and read data
    int          edges_f = 0, acc_f = 0, viol_f = 0;
    logic [20:0] cap_f = '0;
    logic        prev_sclk_f = 1'b0, prev_en_f = 1'b0;
    exp_t        ef;

    always @(negedge clk) begin
        if (!reset_n) begin
            edges_f = 0; viol_f = 0; cap_f = '0; prev_sclk_f = 1'b0; prev_en_f = 1'b0;
        end else begin
            if (bf.sreg_clk && !prev_sclk_f) begin
                cap_f = {cap_f[19:0], bf.sreg_si};
                edges_f++;
            end
            if (bf.sreg_en && prev_en_f && (bf.sreg_clk == prev_sclk_f)) viol_f++;
            if (bf.rsp_valid) begin
                if (fq.size() == 0) begin
                    chk("fast_unexpected_rsp", {31'd0, bf.rsp_valid}, 32'd0);
                end else begin
                    ef = fq.pop_front();
                    chk("fast_latency", cyc - acc_f, 45);
                    chk("fast_sclk_edges", edges_f, 21);
                    chk("fast_shifted_addr", {11'd0, cap_f}, {11'd0, ef.a});
                    chk("fast_rsp_rdata", {24'd0, bf.rsp_rdata}, {24'd0, ef.r});
                    chk("fast_phase_len", viol_f, 0);
                    $display("fast rsp %s addr=%06h rdata=%02h at cycle %0d",
                             ef.w ? "WR" : "RD", cap_f, bf.rsp_rdata, cyc);
                end
            end
            if (bf.cmd_valid && bf.cmd_ready) begin
                acc_f = cyc + 1;
                edges_f = 0; viol_f = 0; cap_f = '0;
            end
            prev_sclk_f = bf.sreg_clk;
            prev_en_f   = bf.sreg_en;
        end
    end

    task automatic issue(input logic w, input logic [20:0] a, input logic [7:0] d,
                         input logic [7:0] r, input bit keep, input bit push, output int acc);
        int   n;
        exp_t x;
        @(posedge clk); #1;
        bm.cmd_valid = 1'b1; bm.cmd_write = w; bm.cmd_addr = a; bm.cmd_wdata = d;
        if (!w) rd_val = r;
        n = 0;
        while (!bm.cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", {31'd0, bm.cmd_ready}, 32'd1);
        if (push) begin
            if (!w) exp_rdata = r;
            x.w = w; x.a = a; x.d = d; x.r = exp_rdata;
            exp_q.push_back(x);
        end
        @(posedge clk); #1;
        acc = cyc;
        if (!keep) bm.cmd_valid = 1'b0;
    endtask

    task automatic issue_f(input logic w, input logic [20:0] a, input logic [7:0] d, input logic [7:0] r);
        int   n;
        exp_t x;
        @(posedge clk); #1;
        bf.cmd_valid = 1'b1; bf.cmd_write = w; bf.cmd_addr = a; bf.cmd_wdata = d;
        if (!w) rd_val_f = r;
        n = 0;
        while (!bf.cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fast_ready_timeout", {31'd0, bf.cmd_ready}, 32'd1);
        if (!w) exp_rdata_f = r;
        x.w = w; x.a = a; x.d = d; x.r = exp_rdata_f;
        fq.push_back(x);
        @(posedge clk); #1;
        bf.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", exp_q.size() + fq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc1, acc2, n;
        bm.cmd_valid = 1'b0; bm.cmd_write = 1'b0; bm.cmd_addr = '0; bm.cmd_wdata = '0;
        bf.cmd_valid = 1'b0; bf.cmd_write = 1'b0; bf.cmd_addr = '0; bf.cmd_wdata = '0;

        // Reset values while reset_n is held low for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sreg", {29'd0, bm.sreg_si, bm.sreg_clk, bm.sreg_en}, 32'd0);
        chk("rst_strobes", {29'd0, bm.bus_ce_n, bm.bus_we_n, bm.bus_oe_n}, 32'h7);
        chk("rst_data", {23'd0, bm.bus_data_oe, bm.bus_data_out}, 32'd0);
        chk("rst_rsp", {23'd0, bm.rsp_valid, bm.rsp_rdata}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'd0, bm.cmd_ready}, 32'd1);

        issue(1'b1, 21'h1ABCDE, 8'h5A, 8'h00, 1'b0, 1'b1, acc1);
        drain();
        issue(1'b0, 21'h000001, 8'h00, 8'hC3, 1'b0, 1'b1, acc1);
        drain();
        issue(1'b1, 21'h0F0F0F, 8'h11, 8'h00, 1'b0, 1'b1, acc1);
        drain();

        // Back-to-back with cmd_valid held across both commands
        issue(1'b0, 21'h155555, 8'h00, 8'h7E, 1'b1, 1'b1, acc1);
        issue(1'b1, 21'h0AAAAA, 8'hA5, 8'h00, 1'b0, 1'b1, acc2);
        chk("b2b_period", acc2 - acc1, 89);
        drain();

        // Abort mid-shift at the 10th sreg_clk rising edge
        issue(1'b1, 21'h1FFFFF, 8'h99, 8'h00, 1'b0, 1'b0, acc1);
        n = 0;
        while (edges < 10 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_edge_wait", edges, 10);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_sreg", {29'd0, bm.sreg_si, bm.sreg_clk, bm.sreg_en}, 32'd0);
        chk("abort_strobes", {29'd0, bm.bus_ce_n, bm.bus_we_n, bm.bus_oe_n}, 32'h7);
        chk("abort_rsp", {23'd0, bm.rsp_valid, bm.rsp_rdata}, 32'd0);
        chk("abort_ready", {31'd0, bm.cmd_ready}, 32'd1);
        reset_n = 1'b1;
        exp_rdata = 8'h00;
        issue(1'b1, 21'h012345, 8'h3C, 8'h00, 1'b0, 1'b1, acc1);
        drain();

        // Fast instance
        issue_f(1'b1, 21'h1ABCDE, 8'h5A, 8'h00);
        drain();
        issue_f(1'b0, 21'h000001, 8'h00, 8'hC3);
        drain();

        chk("queues_empty", exp_q.size() + fq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got %0d cycles, required completion before 30000", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
